// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the mem_unit memory block.
// Contents: FSM state enum, default width constants, even-parity helper.
// Ports: none (package).
package mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W  = 64;

    typedef enum logic {
        BOOT = 1'b0,
        IDLE = 1'b1
    } state_t;

    // Even parity: stored bit makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH-word storage, one synchronous write port, one registered read port.
// Ports: clk/rst (sync, active-high; clears only the read register), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr -> rd_data/rd_perr one cycle later. Optional macro MEM_PARITY_EN adds a parity bit per word.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr
);

`ifdef MEM_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Contents are deliberately not reset: they must survive a reset mid-boot.
    logic [STORE_W-1:0] mem [DEPTH];
    logic [STORE_W-1:0] wr_word;
    logic [STORE_W-1:0] rd_q;

`ifdef MEM_PARITY_EN
    assign wr_word = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
    assign rd_perr = rd_q[DATA_W] ^ (^rd_q[DATA_W-1:0]);
`else
    assign wr_word = wr_data;
    assign rd_perr = 1'b0;
`endif

    // Callers only assert wr_en/rd_en for in-range addresses.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr[IDX_W-1:0]];
        end
    end

    assign rd_data = rd_q[DATA_W-1:0];

endmodule

// File: rtl/mem_unit.sv
// mem_unit: program/data memory with boot-load stream and valid/ready CPU request port.
// Ports: clk, rst (sync active-high); boot_en/boot_valid/boot_data/boot_last -> boot_ready/boot_done;
//        req_valid/req_we/req_addr/req_wdata -> req_ready; rsp_valid/rsp_rdata/rsp_err (1-cycle read latency, no backpressure).
// Optional macro MEM_PARITY_EN: per-word even parity, parity mismatch on read raises rsp_err.
module mem_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_en,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_last,
    output logic              boot_ready,
    output logic              boot_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] boot_ptr_q, boot_ptr_d;
    logic              boot_done_q, boot_done_d;
    logic              rsp_valid_q;
    logic              oor_q;          // last accepted read was out of range

    logic              boot_wr;
    logic              req_acc, wr_acc, rd_acc, in_range;
    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic              arr_perr;

    // Next-state logic. The boot stream stops at the last word even without
    // boot_last so the pointer never wraps back over address 0.
    always_comb begin
        state_d     = state_q;
        boot_ptr_d  = boot_ptr_q;
        boot_done_d = boot_done_q;
        boot_wr     = 1'b0;
        case (state_q)
            BOOT: begin
                if (boot_valid) begin
                    boot_wr = 1'b1;
                    if (boot_last || (boot_ptr_q == LAST_PTR)) begin
                        state_d     = IDLE;
                        boot_done_d = 1'b1;
                    end else begin
                        boot_ptr_d = boot_ptr_q + 1'b1;
                    end
                end else if (!boot_en) begin
                    state_d     = IDLE;
                    boot_done_d = 1'b1;
                end
            end
            IDLE:    state_d = IDLE;
            default: state_d = BOOT;
        endcase
    end

    // Handshakes are masked while rst is high so nothing is accepted during reset.
    assign boot_ready = (state_q == BOOT) && !rst;
    assign req_ready  = (state_q == IDLE) && !rst;
    assign boot_done  = boot_done_q;

    assign req_acc  = req_valid && req_ready;
    assign wr_acc   = req_acc && req_we;
    assign rd_acc   = req_acc && !req_we;
    assign in_range = ({1'b0, req_addr} < DEPTH_L);

    // Single write port shared by boot and CPU; the FSM state selects the source.
    assign arr_we    = (boot_wr && !rst) || (wr_acc && in_range);
    assign arr_waddr = (state_q == BOOT) ? boot_ptr_q : req_addr;
    assign arr_wdata = (state_q == BOOT) ? boot_data  : req_wdata;
    assign arr_re    = rd_acc && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            boot_ptr_q  <= '0;
            boot_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_ptr_q  <= boot_ptr_d;
            boot_done_q <= boot_done_d;
            rsp_valid_q <= rd_acc;
            if (rd_acc) begin
                oor_q <= !in_range;
            end
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (arr_we),
        .wr_addr (arr_waddr),
        .wr_data (arr_wdata),
        .rd_en   (arr_re),
        .rd_addr (req_addr),
        .rd_data (arr_rdata),
        .rd_perr (arr_perr)
    );

    // Out-of-range reads leave the array register untouched; oor_q forces zero
    // data and the error flag, and both hold until the next accepted read.
    assign rsp_valid = rsp_valid_q && !rst;
    assign rsp_rdata = oor_q ? '0 : arr_rdata;
    assign rsp_err   = oor_q | arr_perr;

endmodule

// File: tb/tb_mem_unit.sv
module tb_mem_unit;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    logic          clk;
    logic          rst;
    logic          boot_en, boot_valid, boot_last;
    logic [DW-1:0] boot_data;
    logic          boot_ready, boot_done;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;

    mem_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_en    (boot_en),
        .boot_valid (boot_valid),
        .boot_data  (boot_data),
        .boot_last  (boot_last),
        .boot_ready (boot_ready),
        .boot_done  (boot_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            stamp;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] mm [DEPTH];
    bit            perr_m [DEPTH];
    int            bptr;
    bit            m_idle;
    int            vectors;
    int            miscompares;
    int            cyc;
    logic [DW-1:0] w0, w1, wn;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding read, one cycle after acceptance.
    always @(negedge clk) begin
        if (rsp_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: rsp_valid=%b with no read outstanding (cycle %0d)", rsp_valid, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.d));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.e));
                chk("rsp_latency", cyc, mon_e.stamp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        boot_valid = 1'b0;
        boot_last  = 1'b0;
        boot_data  = '0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
    endtask

    task automatic apply_reset(input bit en);
        idle_inputs();
        rst     = 1'b1;
        boot_en = en;
        sb.delete();
        tick();
        chk("rst_boot_ready", 32'(boot_ready), 0);
        chk("rst_boot_done", 32'(boot_done), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        tick();
        rst    = 1'b0;
        bptr   = 0;
        m_idle = 1'b0;
        #1;
        chk("post_rst_boot_ready", 32'(boot_ready), 1);
        chk("post_rst_boot_done", 32'(boot_done), 0);
    endtask

    task automatic boot_word(input logic [DW-1:0] d, input bit last);
        boot_valid = 1'b1;
        boot_data  = d;
        boot_last  = last;
        #1;
        chk("boot_ready", 32'(boot_ready), 1);
        tick();
        mm[bptr]     = d;
        perr_m[bptr] = 1'b0;
        if (last || bptr == DEPTH - 1) m_idle = 1'b1;
        else bptr++;
        boot_valid = 1'b0;
        boot_last  = 1'b0;
    endtask

    task automatic req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t x;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        chk("req_ready", 32'(req_ready), 32'(m_idle));
        if (m_idle && !we) begin
            x.d     = (int'(a) < DEPTH) ? mm[a] : '0;
            x.e     = (int'(a) < DEPTH) ? perr_m[a] : 1'b1;
            x.stamp = cyc + 1;
            sb.push_back(x);
        end
        tick();
        if (m_idle && we && int'(a) < DEPTH) begin
            mm[a]     = d;
            perr_m[a] = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b1;
        boot_en     = 1'b1;
        idle_inputs();

        // Full-depth boot stream without boot_last, with random gaps.
        apply_reset(1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            boot_word(DW'($urandom), 1'b0);
        end
        chk("full_boot_ready", 32'(boot_ready), 0);
        chk("full_req_ready", 32'(req_ready), 1);
        chk("full_boot_done", 32'(boot_done), 1);
        // Extra boot word after exit must not wrap onto address 0.
        boot_valid = 1'b1;
        boot_data  = 8'hFF;
        tick();
        boot_valid = 1'b0;
        req(1'b0, 8'd0, 8'h00);
        req(1'b0, 8'd1, 8'h00);
        req(1'b0, 8'd199, 8'h00);

        // Out-of-range write and reads.
        req(1'b1, 8'hC8, 8'h5A);
        req(1'b0, 8'hC8, 8'h00);
        req(1'b0, 8'hFF, 8'h00);
        req(1'b0, 8'd150, 8'h00);

        // Random back-to-back traffic with occasional idle cycles.
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) begin
                tick();
            end else begin
                logic [AW-1:0] a;
                a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(200, 255))
                                                : AW'($urandom_range(0, 199));
                req(1'($urandom_range(0, 1)), a, DW'($urandom));
            end
        end
        // Sweep shows out-of-range writes never landed anywhere.
        for (int a = 0; a < DEPTH; a++) req(1'b0, AW'(a), 8'h00);
        drain();

        // Four-word boot with boot_last, then read back.
        apply_reset(1'b1);
        boot_word(8'h21, 1'b0);
        boot_word(8'h38, 1'b0);
        boot_word(8'h30, 1'b0);
        boot_word(8'h4C, 1'b1);
        chk("b4_boot_done", 32'(boot_done), 1);
        chk("b4_req_ready", 32'(req_ready), 1);
        chk("b4_boot_ready", 32'(boot_ready), 0);
        for (int a = 0; a < 5; a++) req(1'b0, AW'(a), 8'h00);
        drain();

        // boot_en=0: straight to IDLE after one cycle.
        apply_reset(1'b0);
        tick();
        m_idle = 1'b1;
        chk("skip_boot_done", 32'(boot_done), 1);
        req(1'b1, 8'h10, 8'hA5);
        req(1'b0, 8'h10, 8'h00);
        drain();

        // Reset after the second word of a three-word boot.
        w0 = DW'($urandom);
        w1 = DW'($urandom);
        wn = DW'($urandom);
        apply_reset(1'b1);
        boot_word(w0, 1'b0);
        boot_word(w1, 1'b0);
        apply_reset(1'b1);
        boot_word(wn, 1'b1);
        chk("mid_boot_done", 32'(boot_done), 1);
        req(1'b0, 8'd0, 8'h00);
        req(1'b0, 8'd1, 8'h00);
        req(1'b0, 8'd2, 8'h00);
        drain();

        // Reset while a read response is pending: it must never appear.
        req(1'b0, 8'd3, 8'h00);
        rst = 1'b1;
        #1;
        chk("pending_discard", 32'(rsp_valid), 0);
        apply_reset(1'b0);
        tick();
        m_idle = 1'b1;
        repeat (3) tick();
        req(1'b0, 8'd3, 8'h00);
        drain();

`ifdef MEM_PARITY_EN
        // Corrupt one stored data bit behind the design's back.
        dut.u_array.mem[5] = dut.u_array.mem[5] ^ 9'h001;
        mm[5]     = mm[5] ^ 8'h01;
        perr_m[5] = 1'b1;
        req(1'b0, 8'd5, 8'h00);
        req(1'b0, 8'd6, 8'h00);
        req(1'b0, 8'd4, 8'h00);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
